// File: rtl/empty_ptr_fifo.sv
// Free-list FIFO of data-table addresses: a circular RAM with a registered read port that
// feeds a one-word show-ahead output register, with a read-acknowledge from the reader.
module empty_ptr_fifo #(
    parameter int unsigned A_WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               srst_i,
    input  logic [A_WIDTH-1:0] add_empty_ptr_i,
    input  logic               add_empty_ptr_en_i,
    output logic [A_WIDTH-1:0] next_empty_ptr_o,
    output logic               next_empty_ptr_val_o,
    input  logic               next_empty_ptr_rd_ack_i,
    output logic               empty_o,
    output logic               full_o,
    output logic [A_WIDTH:0]   used_words_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    localparam int unsigned      Depth    = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] DepthCnt = (A_WIDTH + 1)'(Depth);
    localparam logic [A_WIDTH:0] CntOne   = (A_WIDTH + 1)'(1);
    localparam logic [A_WIDTH-1:0] PtrOne = A_WIDTH'(1);

    logic [A_WIDTH-1:0] mem [Depth];

    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [A_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic [A_WIDTH:0]   used_q, used_d;
    logic [A_WIDTH-1:0] rdata_q;
    logic               inflight_q, inflight_d;
    logic               out_val_q, out_val_d;
    logic [A_WIDTH-1:0] out_data_q, out_data_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic ack_ok;
    logic add_ok;
    logic rd_en;
    logic xfer;

    always_comb begin
        ack_ok = next_empty_ptr_rd_ack_i & out_val_q & ~srst_i;
        // A valid ack frees a slot this cycle, so an add is accepted even when full.
        add_ok = add_empty_ptr_en_i & ~srst_i & (~full_q | ack_ok);
        // rdata_q is the single in-flight slot; refill it whenever it will be free.
        rd_en  = ~srst_i & (ram_cnt_q != '0) & (~out_val_q | ack_ok | ~inflight_q);
        xfer   = ~srst_i & inflight_q & (~out_val_q | ack_ok);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        used_d     = used_q;
        inflight_d = inflight_q;
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (srst_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ram_cnt_d  = '0;
            used_d     = '0;
            inflight_d = 1'b0;
            out_val_d  = 1'b0;
            out_data_d = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end else begin
            if (add_ok) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end

            if (add_ok && !rd_en) begin
                ram_cnt_d = ram_cnt_q + CntOne;
            end else if (!add_ok && rd_en) begin
                ram_cnt_d = ram_cnt_q - CntOne;
            end

            if (add_ok && !ack_ok) begin
                used_d = used_q + CntOne;
            end else if (!add_ok && ack_ok) begin
                used_d = used_q - CntOne;
            end

            inflight_d = rd_en | (inflight_q & ~xfer);

            if (xfer) begin
                out_val_d  = 1'b1;
                out_data_d = rdata_q;
            end else if (ack_ok) begin
                out_val_d  = 1'b0;
            end

            if (add_empty_ptr_en_i && !add_ok) begin
                ovf_d = 1'b1;
            end
            if (next_empty_ptr_rd_ack_i && !out_val_q) begin
                unf_d = 1'b1;
            end
        end

        empty_d = (used_d == '0);
        full_d  = (used_d == DepthCnt);
    end

    // Storage array and its read register carry no reset; validity lives in the counters.
    always_ff @(posedge clk_i) begin
        if (add_ok) begin
            mem[wr_ptr_q] <= add_empty_ptr_i;
        end
        if (rd_en) begin
            rdata_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            used_q     <= '0;
            inflight_q <= 1'b0;
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            used_q     <= used_d;
            inflight_q <= inflight_d;
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign next_empty_ptr_o     = out_data_q;
    assign next_empty_ptr_val_o = out_val_q;
    assign empty_o              = empty_q;
    assign full_o               = full_q;
    assign used_words_o         = used_q;
    assign overflow_o           = ovf_q;
    assign underflow_o          = unf_q;

    // Every stored word sits in exactly one place: RAM, the read register or the output.
    a_count_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
        int'(used_q) == int'(ram_cnt_q) + int'(inflight_q) + int'(out_val_q));

    a_ram_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        ram_cnt_q <= DepthCnt);

endmodule

// File: tb/tb_empty_ptr_fifo.sv
// Bench for empty_ptr_fifo: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_empty_ptr_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       srst;
    logic       add_en;
    logic [3:0] add_ptr;
    logic       ack;
    logic [3:0] ptr;
    logic       val;
    logic       empty;
    logic       full;
    logic [4:0] used;
    logic       ovf;
    logic       unf;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    empty_ptr_fifo #(.A_WIDTH(4)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .srst_i                  (srst),
        .add_empty_ptr_i         (add_ptr),
        .add_empty_ptr_en_i      (add_en),
        .next_empty_ptr_o        (ptr),
        .next_empty_ptr_val_o    (val),
        .next_empty_ptr_rd_ack_i (ack),
        .empty_o                 (empty),
        .full_o                  (full),
        .used_words_o            (used),
        .overflow_o              (ovf),
        .underflow_o             (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: stored pointers in acceptance order, each stamped with the edge that
    // accepted it. The head is visible once it was accepted at least two edges ago.
    int q_val[$];
    int q_t[$];
    int edge_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    function automatic bit m_vis();
        return (q_val.size() > 0) && (q_t[0] <= edge_cnt - 2);
    endfunction

    initial forever begin
        bit vis;
        bit ack_ok;
        bit add_ok;
        @(posedge clk or posedge rst);
        if (rst) begin
            q_val.delete();
            q_t.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            vis = m_vis();
            edge_cnt++;
            if (srst) begin
                q_val.delete();
                q_t.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                ack_ok = ack && vis;
                add_ok = add_en && (q_val.size() < DEPTH || ack_ok);
                if (ack && !vis) m_unf = 1'b1;
                if (add_en && !add_ok) m_ovf = 1'b1;
                if (ack_ok) begin
                    void'(q_val.pop_front());
                    void'(q_t.pop_front());
                end
                if (add_ok) begin
                    q_val.push_back(int'(add_ptr));
                    q_t.push_back(edge_cnt);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            check("m_val", val, m_vis());
            check("m_used", used, q_val.size());
            check("m_empty", empty, q_val.size() == 0);
            check("m_full", full, q_val.size() == DEPTH);
            check("m_ovf", ovf, m_ovf);
            check("m_unf", unf, m_unf);
            if (m_vis()) check("m_ptr", ptr, q_val[0]);
        end
    end

    task automatic cyc(input bit a, input int v, input bit k, input bit s);
        add_en  = a;
        add_ptr = v[3:0];
        ack     = k;
        srst    = s;
        @(negedge clk);
        add_en = 1'b0;
        ack    = 1'b0;
        srst   = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) cyc(1'b1, i, 1'b0, 1'b0);
    endtask

    task automatic init_fill_drain(input string tag);
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, i, 1'b0, 1'b0);
            if (i == 1) check({tag, "_val_before_latency"}, val, 0);
            if (i == 2) begin
                check({tag, "_val_after_latency"}, val, 1);
                check({tag, "_first_ptr"}, ptr, 0);
            end
        end
        check({tag, "_full"}, full, 1);
        check({tag, "_used16"}, used, 16);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_drain_val"}, val, 1);
            check({tag, "_drain_ptr"}, ptr, i);
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        check({tag, "_empty_after"}, empty, 1);
        check({tag, "_val_after"}, val, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int nxt;
        int got;
        bit k;
        bit a;
        rst = 1'b1;
        srst = 1'b0;
        add_en = 1'b0;
        add_ptr = '0;
        ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_val", val, 0);
        check("rst_ptr", ptr, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_used", used, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Scenario 1: initialiser-style fill and back-to-back drain
        init_fill_drain("s1");

        // Scenario 2: add together with ack while full
        fill16();
        repeat (2) cyc(1'b0, 0, 1'b0, 1'b0);
        check("s2_head", ptr, 0);
        cyc(1'b1, 5, 1'b1, 1'b0);
        check("s2_used", used, 16);
        check("s2_ovf", ovf, 0);
        check("s2_next", ptr, 1);
        for (int i = 0; i < 16; i++) begin
            check("s2_drain_ptr", ptr, (i < 15) ? i + 1 : 5);
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        check("s2_empty", empty, 1);

        // Scenario 3: overflow then underflow
        fill16();
        repeat (2) cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 7, 1'b0, 1'b0);
        check("s3_ovf", ovf, 1);
        check("s3_used", used, 16);
        for (int i = 0; i < 16; i++) begin
            check("s3_drain_ptr", ptr, i);
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        repeat (3) cyc(1'b0, 0, 1'b0, 1'b0);
        check("s3_no_seven", val, 0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        check("s3_unf", unf, 1);
        check("s3_used0", used, 0);

        // Scenario 4: soft reset with a read in flight and an add in the same cycle
        for (int i = 0; i < 7; i++) cyc(1'b1, i, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        check("s4_used6", used, 6);
        cyc(1'b1, 8, 1'b0, 1'b1);
        check("s4_val", val, 0);
        check("s4_used", used, 0);
        check("s4_ovf", ovf, 0);
        check("s4_unf", unf, 0);
        check("s4_empty", empty, 1);
        cyc(1'b1, 9, 1'b0, 1'b0);
        check("s4_lat0", val, 0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        check("s4_lat1", val, 0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        check("s4_val9", val, 1);
        check("s4_ptr9", ptr, 9);
        check("s4_used1", used, 1);
        cyc(1'b0, 0, 1'b1, 1'b0);
        check("s4_empty_after", empty, 1);

        // Scenario 5: asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) cyc(1'b1, i, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("s5_val", val, 0);
        check("s5_ptr", ptr, 0);
        check("s5_empty", empty, 1);
        check("s5_full", full, 0);
        check("s5_used", used, 0);
        check("s5_ovf", ovf, 0);
        check("s5_unf", unf, 0);
        @(negedge clk);
        rst = 1'b0;
        init_fill_drain("s5");

        // Scenario 6: paced add/ack across the RAM wrap
        nxt = 0;
        got = 0;
        for (int c = 0; c < 400 && got < 40; c++) begin
            k = m_vis();
            if (k) begin
                check("s6_ptr", ptr, got % 16);
                got++;
            end
            a = (nxt < 40) && (q_val.size() + 1 - (k ? 1 : 0) <= 2);
            check("s6_used_le2", used <= 2, 1);
            cyc(a, nxt % 16, k, 1'b0);
            if (a) nxt++;
        end
        check("s6_all_out", got, 40);
        check("s6_empty", empty, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
